// File: rtl/eth_pcs_tx_gearbox.sv
// eth_pcs_tx_gearbox
//   Packs 66-bit 64b/66b blocks (2-bit sync header + 64-bit payload, supplied
//   W_DATA payload bits per transaction) into a continuous W_DATA-bit word
//   stream for the PMA, one word per clock. Every 33rd cycle is a pause cycle:
//   upstream is stalled via o_clk_en and the accumulated header bits drain.
//
// Ports
//   i_clk        TX PCS clock
//   i_reset      asynchronous active-low reset
//   i_sync_data  sync header, sampled on enabled cycles with o_trans_cnt == 0
//   i_pld_data   payload slice number o_trans_cnt of the current block
//   o_clk_en     upstream clock enable (low on the pause cycle and in reset)
//   o_trans_cnt  transaction index within the current block
//   o_tx_data    word to PMA, bit 0 transmitted first
//   o_hdr_err    one-cycle pulse after an invalid header (00/11) was sampled
module eth_pcs_tx_gearbox #(
  parameter int W_DATA          = 32,
  parameter int W_SYNC          = 2,
  parameter int N_TRANS_PER_BLK = 64 / W_DATA,
  parameter int W_TRANS_PER_BLK = (N_TRANS_PER_BLK > 1) ? $clog2(N_TRANS_PER_BLK) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [W_SYNC-1:0]          i_sync_data,
  input  logic [W_DATA-1:0]          i_pld_data,
  output logic                       o_clk_en,
  output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
  output logic [W_DATA-1:0]          o_tx_data,
  output logic                       o_hdr_err
);

  localparam int W_BUF = 2 * W_DATA;
  localparam int W_RES = $clog2(W_BUF + 1);

  localparam logic [5:0]                 SEQ_PAUSE = 6'd32;
  localparam logic [W_TRANS_PER_BLK-1:0] CNT_LAST  = W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);
  localparam logic [W_RES-1:0]           LEN_WORD  = W_RES'(W_DATA);
  localparam logic [W_RES-1:0]           LEN_BLK0  = W_RES'(W_DATA + W_SYNC);
  localparam logic [W_RES-1:0]           RES_MAX0  = W_RES'(W_DATA - W_SYNC);

  logic [5:0]                 seq_p0;
  logic [W_TRANS_PER_BLK-1:0] cnt_p0;
  logic [W_BUF-1:0]           res_buf_p0;  // residual bits, LSB first; bits above res_len_p0 are zero
  logic [W_RES-1:0]           res_len_p0;

  logic             en;
  logic             blk_start;
  logic             hdr_bad;
  logic [W_BUF-1:0] app_bits;
  logic [W_RES-1:0] app_len;
  logic [W_BUF-1:0] merged;
  logic [W_RES-1:0] len_sum;

  // Enable is decoded from the period counter; reset gating keeps it low while
  // reset is held and lets it rise in the very first cycle after release.
  assign en          = (seq_p0 != SEQ_PAUSE);
  assign o_clk_en    = i_reset & en;
  assign o_trans_cnt = cnt_p0;

  always_comb begin
    app_bits  = '0;
    app_len   = '0;
    blk_start = en && (cnt_p0 == '0);
    hdr_bad   = 1'b0;
    if (en) begin
      if (blk_start) begin
        app_bits[W_DATA+W_SYNC-1:0] = {i_pld_data, i_sync_data};
        app_len                     = LEN_BLK0;
        hdr_bad                     = (i_sync_data == '0) || (i_sync_data == '1);
      end else begin
        app_bits[W_DATA-1:0] = i_pld_data;
        app_len              = LEN_WORD;
      end
    end
    // Residual plus appended chunk never exceeds 2*W_DATA bits, and always
    // holds at least W_DATA bits, so one full word leaves every cycle.
    merged  = res_buf_p0 | (app_bits << res_len_p0);
    len_sum = res_len_p0 + app_len;
  end

  // Stage p0 -> output register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      seq_p0     <= '0;
      cnt_p0     <= '0;
      res_buf_p0 <= '0;
      res_len_p0 <= '0;
      o_tx_data  <= '0;
      o_hdr_err  <= 1'b0;
    end else begin
      seq_p0 <= (seq_p0 == SEQ_PAUSE) ? 6'd0 : seq_p0 + 6'd1;
      if (en) begin
        cnt_p0 <= (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + W_TRANS_PER_BLK'(1);
      end
      res_buf_p0 <= merged >> W_DATA;
      res_len_p0 <= len_sum - LEN_WORD;
      o_tx_data  <= merged[W_DATA-1:0];
      o_hdr_err  <= hdr_bad;
    end
  end

  // Every period begins with an empty residual, and a block start never sees
  // more than W_DATA-2 residual bits.
  a_res_empty_at_seq0: assert property (@(posedge i_clk) disable iff (!i_reset)
    (seq_p0 == 6'd0) |-> (res_len_p0 == '0));
  a_res_bound_at_blk: assert property (@(posedge i_clk) disable iff (!i_reset)
    blk_start |-> (res_len_p0 <= RES_MAX0));

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
module tb_eth_pcs_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sync;
  logic [63:0] pld;

  logic        en16, en32, en64;
  logic [1:0]  cnt16;
  logic [0:0]  cnt32, cnt64;
  logic [15:0] tx16;
  logic [31:0] tx32;
  logic [63:0] tx64;
  logic        err16, err32, err64;

  always #5 clk = ~clk;

  eth_pcs_tx_gearbox #(.W_DATA(16)) dut16 (
    .i_clk(clk), .i_reset(rst_n), .i_sync_data(sync), .i_pld_data(pld[15:0]),
    .o_clk_en(en16), .o_trans_cnt(cnt16), .o_tx_data(tx16), .o_hdr_err(err16));
  eth_pcs_tx_gearbox #(.W_DATA(32)) dut32 (
    .i_clk(clk), .i_reset(rst_n), .i_sync_data(sync), .i_pld_data(pld[31:0]),
    .o_clk_en(en32), .o_trans_cnt(cnt32), .o_tx_data(tx32), .o_hdr_err(err32));
  eth_pcs_tx_gearbox #(.W_DATA(64)) dut64 (
    .i_clk(clk), .i_reset(rst_n), .i_sync_data(sync), .i_pld_data(pld),
    .o_clk_en(en64), .o_trans_cnt(cnt64), .o_tx_data(tx64), .o_hdr_err(err64));

  typedef struct {
    logic [1:0]  sync;
    logic [31:0] pld;
    logic [31:0] tx;
    logic        err;
  } vec_t;
  vec_t tbl[8];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the serial bit stream of blocks, consumed W bits per cycle.
  int          cur_w;
  int          seq_m;
  int          cnt_m;
  bit          q[$];
  logic [63:0] exp_tx;
  logic        exp_err;

  function automatic logic [63:0] act_tx();
    if (cur_w == 16) return {48'd0, tx16};
    else if (cur_w == 32) return {32'd0, tx32};
    else return tx64;
  endfunction

  function automatic logic [63:0] act_cnt();
    if (cur_w == 16) return {62'd0, cnt16};
    else if (cur_w == 32) return {63'd0, cnt32};
    else return {63'd0, cnt64};
  endfunction

  function automatic logic act_en();
    if (cur_w == 16) return en16;
    else if (cur_w == 32) return en32;
    else return en64;
  endfunction

  function automatic logic act_err();
    if (cur_w == 16) return err16;
    else if (cur_w == 32) return err32;
    else return err64;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (W=%0d) at %0t: got %h expected %h", name, cur_w, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    seq_m   = 0;
    cnt_m   = 0;
    q.delete();
    exp_tx  = '0;
    exp_err = 1'b0;
  endtask

  task automatic check_outputs();
    check("clk_en",    {63'd0, act_en()},  {63'd0, (seq_m != 32)});
    check("trans_cnt", act_cnt(),          64'(cnt_m));
    check("tx_data",   act_tx(),           exp_tx);
    check("hdr_err",   {63'd0, act_err()}, {63'd0, exp_err});
  endtask

  // Called at a falling edge: drive inputs, advance model, clock, compare.
  task automatic step(input logic [1:0] s, input logic [63:0] p);
    sync    = s;
    pld     = p;
    exp_err = 1'b0;
    if (seq_m != 32) begin
      if (cnt_m == 0) begin
        q.push_back(s[0]);
        q.push_back(s[1]);
        exp_err = (s == 2'b00) || (s == 2'b11);
      end
      for (int i = 0; i < cur_w; i++) q.push_back(p[i]);
      cnt_m = (cnt_m + 1) % (64 / cur_w);
    end
    seq_m  = (seq_m + 1) % 33;
    exp_tx = '0;
    for (int i = 0; i < cur_w; i++) begin
      if (q.size() > 0) exp_tx[i] = q.pop_front();
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_step();
    logic [1:0] s;
    s = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    step(s, {$urandom(), $urandom()});
  endtask

  // Assert reset between clock edges, confirm asynchronous clear, release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_clk_en",    {63'd0, act_en()},  64'd0);
    check("rst_trans_cnt", act_cnt(),          64'd0);
    check("rst_tx_data",   act_tx(),           64'd0);
    check("rst_hdr_err",   {63'd0, act_err()}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    sync  = 2'b00;
    pld   = '0;
    cur_w = 32;
    model_reset();

    tbl[0] = '{2'b01, 32'h0000_0001, 32'h0000_0005, 1'b0};
    tbl[1] = '{2'b00, 32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[2] = '{2'b10, 32'h0000_0000, 32'h0000_000A, 1'b0};
    tbl[3] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0};
    tbl[4] = '{2'b01, 32'h0000_0000, 32'h0000_001F, 1'b0};
    tbl[5] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[6] = '{2'b11, 32'h0000_0000, 32'h0000_00C0, 1'b1};
    tbl[7] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Initial reset, W=32 directed packing and header checks
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].sync, {32'd0, tbl[i].pld});
      check("tbl_tx",  act_tx(),           {32'd0, tbl[i].tx});
      check("tbl_err", {63'd0, act_err()}, {63'd0, tbl[i].err});
    end

    // W=32 random stream across several pause cycles
    for (int i = 0; i < 100; i++) rand_step();

    // Reset in the middle of a period at seq 17
    for (int i = 0; i < 40 && seq_m != 17; i++) rand_step();
    check("seq_before_rst", 64'(seq_m), 64'd17);
    do_reset();
    for (int i = 0; i < 99; i++) rand_step();

    // Width sweep
    cur_w = 16;
    do_reset();
    for (int i = 0; i < 99; i++) rand_step();

    cur_w = 64;
    do_reset();
    for (int i = 0; i < 99; i++) rand_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
